// File: rtl/mcpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, datapath mux codes, opcodes.
package mcpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_CALC_ADDR = 4'd2,
    S_LW_MEM    = 4'd3,
    S_LW_WB     = 4'd4,
    S_SW_MEM    = 4'd5,
    S_EXEC      = 4'd6,
    S_R_WB      = 4'd7,
    S_BEQ       = 4'd8,
    S_J         = 4'd9,
    S_BNE       = 4'd10,
    S_RI_EXEC   = 4'd11,
    S_RI_WB     = 4'd12,
    S_JAL       = 4'd13,
    S_TRAP      = 4'd14
  } ctrl_state_t;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUB_REGB  = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OPC   = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR = 2'b01;
  localparam logic [1:0] MEMTOREG_PC  = 2'b10;

  localparam logic [5:0] EXE_RTYPE = 6'b000000;
  localparam logic [5:0] EXE_J     = 6'b000010;
  localparam logic [5:0] EXE_JAL   = 6'b000011;
  localparam logic [5:0] EXE_BEQ   = 6'b000100;
  localparam logic [5:0] EXE_BNE   = 6'b000101;
  localparam logic [5:0] EXE_ADDI  = 6'b001000;
  localparam logic [5:0] EXE_SLTI  = 6'b001010;
  localparam logic [5:0] EXE_ANDI  = 6'b001100;
  localparam logic [5:0] EXE_ORI   = 6'b001101;
  localparam logic [5:0] EXE_XORI  = 6'b001110;
  localparam logic [5:0] EXE_LW    = 6'b100011;
  localparam logic [5:0] EXE_SW    = 6'b101011;

  function automatic logic isRiOp(input logic [5:0] op);
    return (op == EXE_ADDI) || (op == EXE_ANDI) || (op == EXE_ORI) ||
           (op == EXE_XORI) || (op == EXE_SLTI);
  endfunction

endpackage

// File: rtl/ctrl_instr_counter.sv
// Retired-instruction counter; wraps modulo 2^CNT_W.
module ctrl_instr_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (inc) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control FSM with memory wait states, JAL, illegal-opcode trap and retire counter.
module multicycle_ctrl_fsm
  import mcpu_ctrl_pkg::*;
#(
  parameter int         OP_W        = 6,
  parameter int         CNT_W       = 32,
  parameter bit         HAS_JAL     = 1'b1,
  parameter bit         HAS_TRAP    = 1'b1,
  parameter logic [1:0] EXC_VEC_SEL = 2'b11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  opCode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             CondSrc,
  output logic [1:0]       PCSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       state
);

  ctrl_state_t stateQ, stateD;

  always_ff @(posedge clk) begin
    if (!rst_n) stateQ <= S_FETCH;
    else        stateQ <= stateD;
  end

  assign state = stateQ;

  always_comb begin
    stateD = S_FETCH;
    case (stateQ)
      S_FETCH:  stateD = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opCode == EXE_LW || opCode == EXE_SW) stateD = S_CALC_ADDR;
        else if (opCode == EXE_BEQ)               stateD = S_BEQ;
        else if (opCode == EXE_BNE)               stateD = S_BNE;
        else if (opCode == EXE_J)                 stateD = S_J;
        else if (HAS_JAL && opCode == EXE_JAL)    stateD = S_JAL;
        else if (isRiOp(opCode))                  stateD = S_RI_EXEC;
        else if (opCode == EXE_RTYPE)             stateD = S_EXEC;
        else                                      stateD = HAS_TRAP ? S_TRAP : S_FETCH;
      end
      S_CALC_ADDR: begin
        if (opCode == EXE_LW)      stateD = S_LW_MEM;
        else if (opCode == EXE_SW) stateD = S_SW_MEM;
      end
      S_LW_MEM:  stateD = mem_ready ? S_LW_WB : S_LW_MEM;
      S_SW_MEM:  stateD = mem_ready ? S_FETCH : S_SW_MEM;
      S_EXEC:    stateD = S_R_WB;
      S_RI_EXEC: stateD = S_RI_WB;
      default:   stateD = S_FETCH;
    endcase
  end

  // Reset holds FETCH mux settings but blocks every write/request so nothing partial escapes.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    CondSrc     = 1'b0;
    PCSrc       = PCSRC_ALU;
    ALUSrcA     = 1'b0;
    ALUSrcB     = ALUB_REGB;
    ALUOp       = ALUOP_ADD;
    RegWrite    = 1'b0;
    RegDst      = REGDST_RT;
    MemtoReg    = MEMTOREG_ALU;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    if (!rst_n) begin
      ALUSrcB = ALUB_FOUR;
    end else begin
      case (stateQ)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = ALUB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE:    ALUSrcB = ALUB_IMMSH;
        S_CALC_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = ALUB_IMM;
        end
        S_LW_MEM: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_LW_WB: begin
          RegWrite   = 1'b1;
          MemtoReg   = MEMTOREG_MDR;
          instr_done = 1'b1;
        end
        S_SW_MEM: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        S_R_WB: begin
          RegWrite   = 1'b1;
          RegDst     = REGDST_RD;
          instr_done = 1'b1;
        end
        S_RI_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = ALUB_IMM;
          ALUOp   = ALUOP_OPC;
        end
        S_RI_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BEQ, S_BNE: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_SUB;
          PCSrc       = PCSRC_ALUOUT;
          PCWriteCond = 1'b1;
          CondSrc     = (stateQ == S_BNE);
          instr_done  = 1'b1;
        end
        S_J: begin
          PCWrite    = 1'b1;
          PCSrc      = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        // Link register takes the current PC, which already holds PC+4.
        S_JAL: begin
          PCWrite    = 1'b1;
          PCSrc      = PCSRC_JUMP;
          RegWrite   = 1'b1;
          RegDst     = REGDST_RA;
          MemtoReg   = MEMTOREG_PC;
          instr_done = 1'b1;
        end
        S_TRAP: begin
          PCWrite    = 1'b1;
          PCSrc      = EXC_VEC_SEL;
          illegal_op = 1'b1;
        end
        default: ;
      endcase
    end
  end

  ctrl_instr_counter #(.CNT_W(CNT_W)) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (instr_done),
    .cnt   (instr_cnt)
  );

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: default, no-trap and 4-bit-counter instances driven in lockstep.
module tb_multicycle_ctrl_fsm;

  localparam logic [3:0] F = 4'd0, DEC = 4'd1, CALC = 4'd2, LWM = 4'd3, LWB = 4'd4,
                         SWM = 4'd5, EX = 4'd6, RWB = 4'd7, BQ = 4'd8, JJ = 4'd9,
                         BN = 4'd10, RIX = 4'd11, RIB = 4'd12, JL = 4'd13, TR = 4'd14;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                         OP_SLTI = 6'b001010, OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
                         OP_XORI = 6'b001110, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BAD = 6'b111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opCode = '0;
  logic mem_ready = 1'b0;

  logic PCWrite, PCWriteCond, CondSrc, ALUSrcA, RegWrite, MemRead, MemWrite, IorD, IRWrite;
  logic instr_done, illegal_op;
  logic [1:0] PCSrc, ALUSrcB, ALUOp, RegDst, MemtoReg;
  logic [31:0] instr_cnt;
  logic [3:0] state;

  // index 0: HAS_TRAP=0 instance, index 1: CNT_W=4 instance
  logic xPCWrite[2], xPCWriteCond[2], xCondSrc[2], xALUSrcA[2], xRegWrite[2], xMemRead[2];
  logic xMemWrite[2], xIorD[2], xIRWrite[2], xDone[2], xIllegal[2];
  logic [1:0] xPCSrc[2], xALUSrcB[2], xALUOp[2], xRegDst[2], xMemtoReg[2];
  logic [3:0] xState[2];
  logic [31:0] ntCnt;
  logic [3:0] c4Cnt;

  logic [3:0] exp_q[$];
  logic mr_q[$];
  int numChecks = 0;
  int numErrors = 0;
  logic [31:0] cntModel = '0;
  bit ntSynced = 1'b1;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .opCode(opCode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .CondSrc(CondSrc), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite),
    .IorD(IorD), .IRWrite(IRWrite), .instr_done(instr_done), .illegal_op(illegal_op),
    .instr_cnt(instr_cnt), .state(state)
  );

  multicycle_ctrl_fsm #(.HAS_TRAP(1'b0)) dutNt (
    .clk(clk), .rst_n(rst_n), .opCode(opCode), .mem_ready(mem_ready),
    .PCWrite(xPCWrite[0]), .PCWriteCond(xPCWriteCond[0]), .CondSrc(xCondSrc[0]), .PCSrc(xPCSrc[0]),
    .ALUSrcA(xALUSrcA[0]), .ALUSrcB(xALUSrcB[0]), .ALUOp(xALUOp[0]), .RegWrite(xRegWrite[0]),
    .RegDst(xRegDst[0]), .MemtoReg(xMemtoReg[0]), .MemRead(xMemRead[0]), .MemWrite(xMemWrite[0]),
    .IorD(xIorD[0]), .IRWrite(xIRWrite[0]), .instr_done(xDone[0]), .illegal_op(xIllegal[0]),
    .instr_cnt(ntCnt), .state(xState[0])
  );

  multicycle_ctrl_fsm #(.CNT_W(4)) dutC4 (
    .clk(clk), .rst_n(rst_n), .opCode(opCode), .mem_ready(mem_ready),
    .PCWrite(xPCWrite[1]), .PCWriteCond(xPCWriteCond[1]), .CondSrc(xCondSrc[1]), .PCSrc(xPCSrc[1]),
    .ALUSrcA(xALUSrcA[1]), .ALUSrcB(xALUSrcB[1]), .ALUOp(xALUOp[1]), .RegWrite(xRegWrite[1]),
    .RegDst(xRegDst[1]), .MemtoReg(xMemtoReg[1]), .MemRead(xMemRead[1]), .MemWrite(xMemWrite[1]),
    .IorD(xIorD[1]), .IRWrite(xIRWrite[1]), .instr_done(xDone[1]), .illegal_op(xIllegal[1]),
    .instr_cnt(c4Cnt), .state(xState[1])
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pushSeg(input logic [3:0] s, input int waits);
    for (int i = 0; i < waits; i++) begin
      exp_q.push_back(s);
      mr_q.push_back(1'b0);
    end
    exp_q.push_back(s);
    mr_q.push_back(1'b1);
  endtask

  // Non-memory states get a random mem_ready, which the FSM must ignore.
  task automatic pushAny(input logic [3:0] s);
    exp_q.push_back(s);
    mr_q.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic runInstr(input logic [5:0] op, input int fWait, input int mWait);
    logic [3:0] es;
    logic mr;
    int nPc, nIr, nReg, nDone, nIll;
    int ePc, eReg;
    bit isTrap;
    nPc = 0; nIr = 0; nReg = 0; nDone = 0; nIll = 0;
    isTrap = 1'b0; ePc = 1; eReg = 0;
    pushSeg(F, fWait);
    pushAny(DEC);
    case (op)
      OP_LW:   begin pushAny(CALC); pushSeg(LWM, mWait); pushAny(LWB); eReg = 1; end
      OP_SW:   begin pushAny(CALC); pushSeg(SWM, mWait); end
      OP_R:    begin pushAny(EX); pushAny(RWB); eReg = 1; end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:
               begin pushAny(RIX); pushAny(RIB); eReg = 1; end
      OP_BEQ:  pushAny(BQ);
      OP_BNE:  pushAny(BN);
      OP_J:    begin pushAny(JJ); ePc = 2; end
      OP_JAL:  begin pushAny(JL); ePc = 2; eReg = 1; end
      default: begin pushAny(TR); ePc = 2; isTrap = 1'b1; end
    endcase
    while (exp_q.size() > 0) begin
      es = exp_q.pop_front();
      mr = mr_q.pop_front();
      @(negedge clk);
      opCode = op;
      mem_ready = mr;
      #1;
      checkVal("state", state, es);
      if (ntSynced) checkVal("nt_state", xState[0], (es == TR) ? F : es);
      nPc += PCWrite; nIr += IRWrite; nReg += RegWrite; nDone += instr_done; nIll += illegal_op;
      case (es)
        F: begin
          checkVal("fetch_memread", MemRead, 1);
          checkVal("fetch_alusrcb", ALUSrcB, 2'b01);
          checkVal("fetch_irwrite", IRWrite, mr);
        end
        DEC: checkVal("decode_alusrcb", ALUSrcB, 2'b11);
        CALC: checkVal("calc_alusrcb", ALUSrcB, 2'b10);
        LWM: checkVal("lwmem_iord", {MemRead, IorD, RegWrite}, 3'b110);
        LWB: checkVal("lwwb_memtoreg", MemtoReg, 2'b01);
        SWM: begin
          checkVal("swmem_write", {MemWrite, IorD}, 2'b11);
          checkVal("swmem_done", instr_done, mr);
        end
        EX:  checkVal("exec_aluop", {ALUSrcA, ALUOp}, 3'b110);
        RWB: checkVal("rwb_regdst", RegDst, 2'b01);
        RIX: checkVal("riexec_ctl", {ALUSrcA, ALUSrcB, ALUOp}, 5'b11011);
        BQ, BN: begin
          checkVal("br_condsrc", CondSrc, (es == BN));
          checkVal("br_ctl", {PCWriteCond, PCSrc, ALUOp, ALUSrcA}, 6'b101011);
        end
        JJ: checkVal("j_pcsrc", PCSrc, 2'b10);
        JL: begin
          checkVal("jal_pc", {PCWrite, PCSrc}, 3'b110);
          checkVal("jal_wr", {RegWrite, RegDst, MemtoReg}, 5'b11010);
          checkVal("jal_done", instr_done, 1);
        end
        TR: begin
          checkVal("trap_pcsrc", PCSrc, 2'b11);
          checkVal("trap_flags", {illegal_op, instr_done, PCWrite}, 3'b101);
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    if (!isTrap) cntModel = cntModel + 1;
    if (isTrap) ntSynced = 1'b0;
    checkVal("next_fetch", state, F);
    checkVal("pcwrite_pulses", nPc, ePc);
    checkVal("irwrite_pulses", nIr, 1);
    checkVal("regwrite_pulses", nReg, eReg);
    checkVal("done_pulses", nDone, isTrap ? 0 : 1);
    checkVal("illegal_pulses", nIll, isTrap ? 1 : 0);
    checkVal("instr_cnt", instr_cnt, cntModel);
    checkVal("cnt4", c4Cnt, cntModel[3:0]);
  endtask

  // Takes an R-type to R_WB, then holds reset there for two cycles.
  task automatic resetMid();
    logic [3:0] seq[4];
    seq[0] = F; seq[1] = DEC; seq[2] = EX; seq[3] = RWB;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      opCode = OP_R;
      mem_ready = 1'b1;
      #1;
      checkVal("mid_state", state, seq[i]);
    end
    checkVal("mid_regwrite_pre", RegWrite, 1);
    rst_n = 1'b0;
    #1;
    checkVal("rst_regwrite_forced", {RegWrite, instr_done}, 2'b00);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkVal("rst_state", state, F);
      checkVal("rst_cnt", instr_cnt, 0);
      checkVal("rst_regwrite", RegWrite, 0);
      checkVal("rst_enables", {PCWrite, IRWrite, MemRead, PCWriteCond, MemWrite}, 0);
      checkVal("rst_alusrcb", ALUSrcB, 2'b01);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    cntModel = '0;
    ntSynced = 1'b1;
  endtask

  initial begin
    logic [5:0] opTab[14];
    opTab = '{OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
              OP_XORI, OP_LW, OP_SW, OP_BAD, 6'b010000};

    repeat (2) @(posedge clk);
    #1;
    checkVal("init_state", state, F);
    checkVal("init_cnt", instr_cnt, 0);
    checkVal("init_cnt4", c4Cnt, 0);
    checkVal("init_enables", {PCWrite, IRWrite, MemRead, RegWrite, illegal_op}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    runInstr(OP_LW, 3, 2);
    runInstr(OP_SW, 1, 1);
    runInstr(OP_R, 0, 0);
    runInstr(OP_ADDI, 0, 0);
    runInstr(OP_JAL, 0, 0);
    runInstr(OP_BNE, 0, 0);
    runInstr(OP_BEQ, 0, 0);
    runInstr(OP_J, 2, 0);
    runInstr(OP_BAD, 0, 0);
    resetMid();

    for (int i = 0; i < 15; i++) runInstr(OP_R, $urandom_range(0, 2), 0);
    checkVal("cnt4_prewrap", c4Cnt, 4'd15);
    runInstr(OP_R, 0, 0);
    checkVal("cnt4_wrap", c4Cnt, 4'd0);
    checkVal("cnt32_nowrap", instr_cnt, 32'd16);

    for (int i = 0; i < 30; i++)
      runInstr(opTab[$urandom_range(0, 13)], $urandom_range(0, 3), $urandom_range(0, 3));

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
